if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word presented when the IF/ID slot is invalid.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SwitchClk_10  in  1  clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 stall  in  1  downstream decode hold request.
REQ-007 flush  in  1  squash the IF/ID slot.
REQ-008 redirect_valid  in  1  branch/jump taken.
REQ-009 redirect_pc  in  32  target address.
REQ-010 imem_addr  out  32  instruction memory address, driven from PC register.
REQ-011 imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-012 imem_ready  in  1  memory completes the current fetch this cycle.
REQ-013 if_id_valid  out  1  IF/ID slot holds a real instruction.
REQ-014 if_id_instr  out  32  fetched instruction.
REQ-015 if_id_pc  out  32  address of if_id_instr (CurrentPC).
REQ-016 if_id_pc4  out  32  if_id_pc + 4.

Function
REQ-017 SHALL implement FSM states BOOT, FETCH, HELD.
REQ-018 BOOT: one cycle after reset release, imem_addr=RESET_PC, if_id_valid=0, then FETCH.
REQ-019 FETCH, imem_ready=1, stall=0: IF/ID <= {imem_rdata, pc, pc+4}, valid=1, pc <= pc+4.
REQ-020 FETCH, imem_ready=1, stall=1: word captured in 1-entry skid buffer, pc <= pc+4, IF/ID unchanged, go HELD.
REQ-021 FETCH, imem_ready=0: imem_addr held; IF/ID valid <= 0 if stall=0, unchanged if stall=1.
REQ-022 HELD: imem_addr held, no new fetch accepted; when stall=0, IF/ID <= skid entry, valid=1, go FETCH.
REQ-023 redirect_valid SHALL have top priority: pc <= redirect_pc, skid discarded, if_id_valid <= 0, state <= FETCH, regardless of stall or imem_ready.
REQ-024 flush without redirect SHALL clear if_id_valid next cycle even when stall=1; skid entry is kept.
REQ-025 if_id_instr SHALL read NOP_INSTR whenever if_id_valid=0.
REQ-026 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
REQ-027 Fetch-to-IF/ID latency SHALL be exactly one cycle after the imem_ready cycle when not stalled.
REQ-028 redirect_pc bits [1:0] SHALL be forced to 0.

Reset
REQ-029 On reset=0: state=BOOT, pc=RESET_PC, skid empty, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=RESET_PC, if_id_pc4=RESET_PC+4, counters 0.
REQ-030 Reset asserted mid-fetch or in HELD SHALL discard the pending word immediately, no output glitch beyond the reset values.

Configuration
REQ-031 Macro IF_STAGE_PERF_CNT_EN defined: adds outputs fetch_cnt (32, increments per word loaded into IF/ID) and stall_cnt (32, increments per cycle with stall=1 and if_id_valid=1), both wrapping.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Shared package if_pkg SHALL hold the FSM state typedef, PC width constant (32), PC increment (4), and default NOP value.
REQ-034 Skid buffer SHALL be sub-module if_skid_buf (load, drain, clear, valid flag, 64-bit payload instr+pc).

Verification
REQ-035 Reset release, imem_ready=1 constantly, rdata=addr: cycle 2 if_id_pc=0, cycle 3 if_id_pc=4, if_id_instr=4.
REQ-036 stall=1 for 3 cycles on a ready fetch: IF/ID held, imem_addr frozen at pc+4, on release the skid word appears, no word lost or duplicated.
REQ-037 redirect_valid=1, redirect_pc=32'h0000_0103 during HELD: next imem_addr=32'h0000_0100, if_id_valid=0, skid empty.
REQ-038 imem_ready=0 for 2 cycles, stall=0: if_id_valid=0 for 2 cycles, if_id_instr=NOP_INSTR, imem_addr unchanged.
REQ-039 flush=1 with stall=1: if_id_valid=0 next cycle; after stall drop, skid word presented with valid=1.
REQ-040 With IF_STAGE_PERF_CNT_EN, 10 fetches plus 3 stalled-valid cycles: fetch_cnt=10, stall_cnt=3; async reset mid-run clears both to 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] PC_INC = 32'd4;
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HELD  = 2'd2
   } if_state_t;

   // One parked fetch: instruction word and the address it came from.
   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
   } skid_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid register for a word fetched while decode is stalled.
// Latency: load is visible next cycle. Priority: clear > load > drain.
module if_skid_buf
   import if_pkg::*;
(
   input  logic        SwitchClk_10,
   input  logic        reset,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  skid_entry_t load_dat,
   output logic        skid_vld,
   output skid_entry_t skid_dat
);

   always_ff @(posedge SwitchClk_10 or negedge reset) begin
      if (!reset) begin
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else if (clear) begin
         skid_vld <= 1'b0;
      end else if (load) begin
         skid_vld <= 1'b1;
         skid_dat <= load_dat;
      end else if (drain) begin
         skid_vld <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID slot, one-word skid buffer.
// Latency: fetched word lands in IF/ID one cycle after imem_ready; stall parks it in the skid.
// Optional IF_STAGE_PERF_CNT_EN adds fetch_cnt/stall_cnt outputs.
module if_stage
   import if_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0]     NOP_INSTR = NOP_DEFAULT
) (
   input  logic            SwitchClk_10,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_ready,
   output logic            if_id_valid,
   output logic [31:0]     if_id_instr,
   output logic [PC_W-1:0] if_id_pc,
   output logic [PC_W-1:0] if_id_pc4
`ifdef IF_STAGE_PERF_CNT_EN
   ,
   output logic [31:0]     fetch_cnt,
   output logic [31:0]     stall_cnt
`endif
);

   if_state_t       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            vld_q, vld_d;
   logic [31:0]     instr_q, instr_d;
   logic [PC_W-1:0] ipc_q, ipc_d;

   logic            skid_load, skid_drain, skid_clear, skid_vld;
   skid_entry_t     skid_dat, skid_in;

   assign skid_in = '{instr: imem_rdata, pc: pc_q};

   if_skid_buf u_skid (
      .SwitchClk_10 (SwitchClk_10),
      .reset        (reset),
      .load         (skid_load),
      .drain        (skid_drain),
      .clear        (skid_clear),
      .load_dat     (skid_in),
      .skid_vld     (skid_vld),
      .skid_dat     (skid_dat)
   );

   always_ff @(posedge SwitchClk_10 or negedge reset) begin
      if (!reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         vld_q   <= 1'b0;
         instr_q <= NOP_INSTR;
         ipc_q   <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         vld_q   <= vld_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      vld_d      = vld_q;
      instr_d    = instr_q;
      ipc_d      = ipc_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_clear = 1'b0;
      if (redirect_valid) begin
         pc_d       = redirect_pc & ~32'h3;
         skid_clear = 1'b1;
         vld_d      = 1'b0;
         state_d    = FETCH;
      end else begin
         case (state_q)
            BOOT: begin
               vld_d   = 1'b0;
               state_d = FETCH;
            end
            FETCH: begin
               if (imem_ready) begin
                  pc_d = pc_q + PC_INC;
                  if (stall) begin
                     skid_load = 1'b1;
                     state_d   = HELD;
                     if (flush) vld_d = 1'b0;
                  end else if (flush) begin
                     vld_d = 1'b0;
                  end else begin
                     instr_d = imem_rdata;
                     ipc_d   = pc_q;
                     vld_d   = 1'b1;
                  end
               end else if (flush || !stall) begin
                  vld_d = 1'b0;
               end
            end
            HELD: begin
               // Flush squashes only the slot; the parked word still drains later.
               if (flush) begin
                  vld_d = 1'b0;
               end else if (!stall) begin
                  skid_drain = 1'b1;
                  instr_d    = skid_dat.instr;
                  ipc_d      = skid_dat.pc;
                  vld_d      = 1'b1;
                  state_d    = FETCH;
               end
            end
            default: state_d = BOOT;
         endcase
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_valid = vld_q;
   assign if_id_instr = vld_q ? instr_q : NOP_INSTR;
   assign if_id_pc    = ipc_q;
   assign if_id_pc4   = ipc_q + PC_INC;

`ifdef IF_STAGE_PERF_CNT_EN
   logic if_load;
   assign if_load = !redirect_valid && !stall && !flush &&
                    ((state_q == FETCH && imem_ready) || (state_q == HELD && skid_vld));

   always_ff @(posedge SwitchClk_10 or negedge reset) begin
      if (!reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (if_load)         fetch_cnt <= fetch_cnt + 32'd1;
         if (stall && vld_q)  stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   logic unused_skid_vld;
   assign unused_skid_vld = skid_vld;
`endif

endmodule
